door_close_seq: RTL
===================

# door_close_seq

Parametrised door-close sequencer for the elevator door path: arms when the door has been driven open, waits for the close-permission pulse `c_100` to fall, holds a configurable pre-close safety delay, then drives `close_signal` for a configurable closing time. Any reopen cause during closing aborts the sequence and requests a reopen. An optional nudge mode forces a slow, non-abortable-by-button close after repeated reopens. It sits between the door-open driver (source of `open_signal`) and the door motor close input.

## Interface
- `PRE_CYC`, 6: pre-close delay in cycles; 1..2^CNT_W.
- `CLOSE_CYC`, 31: normal closing duration in cycles; 1..2^CNT_W.
- `NUDGE_CYC`, 62: nudge closing duration in cycles; 1..2^CNT_W; used only with DOOR_NUDGE_EN.
- `MAX_REOPEN`, 3: consecutive aborts before nudge; ≥1; used only with DOOR_NUDGE_EN.
- `CNT_W`, 7: phase counter width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `open_signal` in 1: door-open drive active; arms the sequencer; aborts closing.
- `c_100` in 1: close-permission pulse; its falling edge permits closing.
- `r` in 1: passenger open-button.
- `obstruct` in 1: door-edge sensor; aborts closing in every mode.
- `close_signal` out 1: close motor drive, registered.
- `reopen_req` out 1: one-cycle pulse on abort.
- `close_done` out 1: one-cycle pulse on completed close.
- `busy` out 1: high in WAIT, PRE, or CLOSING.
- `nudge` out 1: nudge mode active; constant 0 without DOOR_NUDGE_EN.

## Operation
- `armed` flag: set on any cycle with `open_signal`=1; cleared on completion or abort (same cycle `open_signal`=1 re-sets it).
- States: IDLE, WAIT, PRE, CLOSING.
  - IDLE: `c_100`=1 and `armed`=1 → WAIT.
  - WAIT: `c_100`=0 → PRE, cnt=0.
  - PRE: `r`=1 → WAIT, cnt=0, unless `nudge`=1. Otherwise cnt increments; at cnt=PRE_CYC-1 → CLOSING, cnt=0, `close_signal`←1.
  - CLOSING: abort priority `obstruct` > `open_signal` > `r` (`r` ignored when `nudge`=1). On abort: `close_signal`←0, `reopen_req` pulses, `armed` cleared, → IDLE. Otherwise cnt increments; at cnt=DUR-1 (DUR = NUDGE_CYC if `nudge` else CLOSE_CYC): `close_signal`←0, `close_done` pulses, `armed` cleared, reopen count cleared, `nudge`←0, → IDLE.
- Abort and timeout in the same cycle: abort wins.
- `open_signal`=1 in WAIT or PRE: stay, `armed` stays 1.
- Counter never wraps; equality compare only. Parameters out of range are illegal and unchecked.

## Timing
- Reset values: `close_signal`=0, `reopen_req`=0, `close_done`=0, `busy`=0, `nudge`=0, state IDLE, cnt=0, `armed`=0, reopen count=0.
- `rst` mid-closing: `close_signal` low the cycle after the sampling edge; no `reopen_req`.
- `c_100`=0 sampled in WAIT at edge t → `close_signal` high after edge t+PRE_CYC.
- `close_signal` stays high for exactly DUR cycles absent abort. `close_done` is asserted in the first cycle `close_signal` is low.
- Abort sampled at edge t → `close_signal`=0 and `reopen_req`=1 after edge t, both in the same cycle.

## Configuration
- `DOOR_NUDGE_EN` defined:
  - A saturating reopen counter of width $clog2(MAX_REOPEN+1) increments on each abort.
  - When the count reaches MAX_REOPEN, `nudge`←1 with the abort.
  - Next sequence: `r` is ignored in PRE/CLOSING and DUR=NUDGE_CYC. `obstruct` and `open_signal` still abort.
- `DOOR_NUDGE_EN` undefined: no counter, `nudge` tied 0, DUR always CLOSE_CYC.

## Test plan
- Defaults, `open_signal` pulse, `c_100` 1→0 at edge t → `close_signal` rises after t+6, high 31 cycles, `close_done` one pulse, `busy` low after.
- `obstruct`=1 at CLOSING cycle 10 → `close_signal`=0 and `reopen_req`=1 next cycle. A subsequent `c_100` fall without a new `open_signal` → no close.
- `r`=1 at PRE cycle 3 → back to WAIT. Next `c_100` fall restarts the full 6-cycle delay.
- `obstruct` and timeout on the same cycle (cycle 30) → `reopen_req`=1, `close_done`=0.
- DOOR_NUDGE_EN, MAX_REOPEN=3: three `r` aborts → `nudge`=1. Fourth sequence ignores `r`, `close_signal` high 62 cycles, then `nudge`=0.
- `rst`=1 during CLOSING → all outputs 0 next cycle, state IDLE, `armed`=0.

Source files
------------

// File: rtl/door_close_seq.sv
// door_close_seq: door-close sequencer for the elevator door path.
// After the door has been driven open it waits for the falling edge of c_100,
// holds a pre-close safety delay, then drives close_signal for the closing
// time. A reopen cause during closing aborts the close and requests a reopen.
// Optional feature macro: DOOR_NUDGE_EN adds nudge mode, entered after
// MAX_REOPEN consecutive aborts. In nudge mode the open-button is ignored and
// the door closes slowly over NUDGE_CYC cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | not sequencing; leaves when armed and c_100 is high
// WAIT    | armed, waiting for c_100 to go low
// PRE     | pre-close safety delay, PRE_CYC cycles
// CLOSING | close motor driven for DUR cycles, abortable

module door_close_seq #(
    parameter int PRE_CYC    = 6,
    parameter int CLOSE_CYC  = 31,
    parameter int NUDGE_CYC  = 62,
    parameter int MAX_REOPEN = 3,
    parameter int CNT_W      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic open_signal,
    input  logic c_100,
    input  logic r,
    input  logic obstruct,
    output logic close_signal,
    output logic reopen_req,
    output logic close_done,
    output logic busy,
    output logic nudge
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        PRE     = 2'd2,
        CLOSING = 2'd3
    } state_t;

    // Terminal counts; the counter only counts up and is compared for equality.
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_CYC - 1);
    localparam logic [CNT_W-1:0] NUDGE_LAST = CNT_W'(NUDGE_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             close_d, reopen_d, done_d;
    logic             abort, finish;
    logic [CNT_W-1:0] dur_last;

`ifdef DOOR_NUDGE_EN
    localparam int RC_W = $clog2(MAX_REOPEN + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_REOPEN);

    logic [RC_W-1:0] rcnt_q;
    logic            nudge_q;

    // Saturating count of consecutive aborts; nudge latches when it reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_q  <= '0;
            nudge_q <= 1'b0;
        end else if (finish) begin
            rcnt_q  <= '0;
            nudge_q <= 1'b0;
        end else if (abort) begin
            if (rcnt_q != RC_MAX) begin
                rcnt_q <= rcnt_q + 1'b1;
            end
            if (rcnt_q >= RC_MAX - 1'b1) begin
                nudge_q <= 1'b1;
            end
        end
    end

    assign nudge = nudge_q;
`else
    // Nudge parameters have no effect in this build.
    logic unused_nudge_cfg;
    assign unused_nudge_cfg = (MAX_REOPEN > 0);
    assign nudge = 1'b0;
`endif

    assign dur_last = nudge ? NUDGE_LAST : CLOSE_LAST;
    assign busy     = (state_q != IDLE);

    // Next-state, phase counter and registered-output next values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        close_d  = 1'b0;
        reopen_d = 1'b0;
        done_d   = 1'b0;
        abort    = 1'b0;
        finish   = 1'b0;
        case (state_q)
            IDLE: begin
                if (c_100 && armed_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!c_100) begin
                    state_d = PRE;
                    cnt_d   = '0;
                end
            end
            PRE: begin
                if (r && !nudge) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == PRE_LAST) begin
                    state_d = CLOSING;
                    cnt_d   = '0;
                    close_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLOSING: begin
                close_d = 1'b1;
                // Abort outranks the terminal count on the same cycle.
                if (obstruct || open_signal || (r && !nudge)) begin
                    abort    = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                    close_d  = 1'b0;
                    reopen_d = 1'b1;
                end else if (cnt_q == dur_last) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    close_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // open_signal re-arms even on the cycle a sequence ends.
        armed_d = open_signal | (armed_q & ~(abort | finish));
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            close_signal <= 1'b0;
            reopen_req   <= 1'b0;
            close_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            close_signal <= close_d;
            reopen_req   <= reopen_d;
            close_done   <= done_d;
        end
    end

endmodule
